vslc_servo_bank: RTL and testbench

VSLC_SERVO_BANK -- requirements
Module: vslc_servo_bank

---
 rtl/vslc_servo_pkg.sv | 12 +
 rtl/vslc_servo_chan.sv | 49 ++++
 rtl/vslc_servo_bank.sv | 90 +++++++++
 tb/tb_vslc_servo_bank.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vslc_servo_pkg.sv
// Shared constants and helpers for the servo PWM bank.
package vslc_servo_pkg;

   localparam int VSLC_NCH_DEF = 4;
   localparam int VSLC_CW_DEF  = 8;

   // Channel address width; a single channel still gets a 1-bit address.
   function automatic int vslc_aw(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/vslc_servo_chan.sv
// One servo channel: shadow width, active width, latched enable and the
// registered PWM compare. Active state only moves on the frame boundary.
module vslc_servo_chan
   import vslc_servo_pkg::*;
#(
   parameter int CW = VSLC_CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          boundary,
   input  logic          wr_sel,
   input  logic [CW-1:0] wr_data,
   input  logic          en_in,
   input  logic [CW-1:0] cnt_nxt,
   output logic          pwm
);

   logic [CW-1:0] shadow_q, shadow_d;
   logic [CW-1:0] act_q, act_d;
   logic          en_q, en_d;
   logic          pwm_q, pwm_d;

   // Next state: a boundary-cycle write goes straight through shadow_d into
   // the active copy, so it governs the frame starting next cycle. The
   // output is computed from next-cycle count/width so the registered pin
   // lines up with the count it describes.
   always_comb begin
      shadow_d = wr_sel ? wr_data : shadow_q;
      act_d    = boundary ? shadow_d : act_q;
      en_d     = boundary ? en_in : en_q;
      if (!rst_n) begin
         shadow_d = '0;
         act_d    = '0;
         en_d     = 1'b0;
      end
      pwm_d = en_d && (cnt_nxt < act_d);
   end

   // State registers
   always_ff @(posedge clk) begin
      shadow_q <= shadow_d;
      act_q    <= act_d;
      en_q     <= en_d;
      pwm_q    <= pwm_d;
   end

   assign pwm = pwm_q;

endmodule

// File: rtl/vslc_servo_bank.sv
// Bank of NCH servo PWM channels sharing one frame counter. Widths, enables
// and the period are double-buffered and take effect at frame boundaries.
module vslc_servo_bank
   import vslc_servo_pkg::*;
#(
   parameter int NCH = VSLC_NCH_DEF,
   parameter int CW  = VSLC_CW_DEF,
   parameter int AW  = vslc_aw(NCH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [CW-1:0]  period,
   input  logic [NCH-1:0] ch_en,
   input  logic           wr_en,
   input  logic [AW-1:0]  wr_ch,
   input  logic [CW-1:0]  wr_data,
   output logic [NCH-1:0] servo_out,
   output logic           frame_start,
   output logic           upd_pending
);

   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  period_act_q, period_act_d;
   logic           frame_start_q, frame_start_d;
   logic           upd_pending_q, upd_pending_d;
   logic           boundary;
   logic [NCH-1:0] wr_sel;
   logic           wr_acc;

   // Write decode: one-hot select, out-of-range addresses select nothing.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NCH; i++)
         wr_sel[i] = wr_en && (int'(wr_ch) == i);
   end

   assign wr_acc = |wr_sel;

   // Counter, latched period and pending flag. cnt never exceeds
   // period_act (both only jump at the boundary), so the increment cannot
   // wrap. A boundary-cycle write is transferred at once, so the boundary
   // clears pending unconditionally.
   always_comb begin
      boundary      = (cnt_q == period_act_q);
      cnt_d         = cnt_q + 1'b1;
      period_act_d  = period_act_q;
      upd_pending_d = upd_pending_q;
      if (boundary) begin
         cnt_d         = '0;
         period_act_d  = period;
         upd_pending_d = 1'b0;
      end else if (wr_acc) begin
         upd_pending_d = 1'b1;
      end
      if (!rst_n) begin
         cnt_d         = '0;
         period_act_d  = period;
         upd_pending_d = 1'b0;
      end
      frame_start_d = (cnt_d == '0);
   end

   // Shared state registers
   always_ff @(posedge clk) begin
      cnt_q         <= cnt_d;
      period_act_q  <= period_act_d;
      frame_start_q <= frame_start_d;
      upd_pending_q <= upd_pending_d;
   end

   // The flag tracks cnt==0 and is therefore already set through reset,
   // giving a pulse on the first cycle after release; the gate keeps the
   // pin low while reset is still held.
   assign frame_start = frame_start_q & rst_n;
   assign upd_pending = upd_pending_q;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      vslc_servo_chan #(.CW(CW)) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .boundary (boundary),
         .wr_sel   (wr_sel[g]),
         .wr_data  (wr_data),
         .en_in    (ch_en[g]),
         .cnt_nxt  (cnt_d),
         .pwm      (servo_out[g])
      );
   end

endmodule

// File: tb/tb_vslc_servo_bank.sv
// Bench for vslc_servo_bank: a 4-channel and a 3-channel instance share
// stimulus; both are compared every cycle against a frame-level model.
module tb_vslc_servo_bank;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] period;
   logic [3:0]    ch_en;
   logic          wr_en;
   logic [1:0]    wr_ch;
   logic [CW-1:0] wr_data;
   logic [3:0]    so_a;
   logic          fs_a, up_a;
   logic [2:0]    so_b;
   logic          fs_b, up_b;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   vslc_servo_bank #(.NCH(4), .CW(CW)) u_a (
      .clk(clk), .rst_n(rst_n), .period(period), .ch_en(ch_en),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .servo_out(so_a), .frame_start(fs_a), .upd_pending(up_a)
   );

   vslc_servo_bank #(.NCH(3), .CW(CW)) u_b (
      .clk(clk), .rst_n(rst_n), .period(period), .ch_en(ch_en[2:0]),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .servo_out(so_b), .frame_start(fs_b), .upd_pending(up_b)
   );

   // Reference model: state of each instance as plain integers.
   int nch [2] = '{4, 3};
   int m_cnt [2];
   int m_pact [2];
   int m_pend [2];
   int m_sh [2][4];
   int m_act [2][4];
   int m_en [2][4];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the rules: writes hit the shadow; at the end of the
   // last frame cycle everything is copied and the frame restarts.
   task automatic model_step();
      bit acc;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            m_cnt[d] = 0; m_pact[d] = int'(period); m_pend[d] = 0;
            for (int k = 0; k < 4; k++) begin
               m_sh[d][k] = 0; m_act[d][k] = 0; m_en[d][k] = 0;
            end
         end else begin
            acc = wr_en && (int'(wr_ch) < nch[d]);
            if (acc) m_sh[d][wr_ch] = int'(wr_data);
            if (m_cnt[d] == m_pact[d]) begin
               m_cnt[d] = 0; m_pact[d] = int'(period); m_pend[d] = 0;
               for (int k = 0; k < nch[d]; k++) begin
                  m_act[d][k] = m_sh[d][k];
                  m_en[d][k]  = int'(ch_en[k]);
               end
            end else begin
               m_cnt[d]++;
               if (acc) m_pend[d] = 1;
            end
         end
      end
   endtask

   function automatic int exp_servo(input int d);
      int e = 0;
      for (int k = 0; k < nch[d]; k++)
         if (m_en[d][k] != 0 && m_cnt[d] < m_act[d][k]) e |= (1 << k);
      return e;
   endfunction

   task automatic check_all();
      chk("a_servo", 32'(so_a), exp_servo(0));
      chk("a_fs",    32'(fs_a), (rst_n && m_cnt[0] == 0) ? 1 : 0);
      chk("a_upd",   32'(up_a), m_pend[0]);
      chk("b_servo", 32'(so_b), exp_servo(1));
      chk("b_fs",    32'(fs_b), (rst_n && m_cnt[1] == 0) ? 1 : 0);
      chk("b_upd",   32'(up_b), m_pend[1]);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wr(input int ch, input int data);
      wr_en = 1'b1; wr_ch = 2'(ch); wr_data = CW'(data);
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic wait_cnt(input int x);
      int n = 0;
      while (m_cnt[0] != x && n < 600) begin
         cyc();
         n++;
      end
      chk("wait_cnt", 32'(n < 600), 1);
   endtask

   initial begin
      int last;
      rst_n = 1'b0; period = 8'd19; ch_en = 4'b0000;
      wr_en = 1'b0; wr_ch = 2'd0; wr_data = '0;
      run(3);
      rst_n = 1'b1;
      #1;
      check_all();
      chk("rel_fs", 32'(fs_a), 1);

      // Basic widths, mid-frame writes, frame_start spacing
      ch_en = 4'b0011;
      wait_cnt(7);
      wr(0, 5);
      wr(1, 10);
      last = -1;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (fs_a) begin
            if (last >= 0) chk("fs_gap", 32'(i - last), 20);
            last = i;
         end
      end

      // Width 0 and width above period
      wr(0, 0);
      wr(1, 25);
      run(45);

      // Last write in the boundary cycle wins
      wait_cnt(18);
      wr(0, 7);
      chk("pend_set", 32'(up_a), 1);
      wr(0, 3);
      chk("pend_clr", 32'(up_a), 0);
      run(25);

      // Mid-frame period/enable change waits for the boundary
      wr(0, 5);
      wr(1, 10);
      wait_cnt(0);
      wait_cnt(6);
      period = 8'd9; ch_en = 4'b0001;
      run(40);

      // Reset while ch0 is high
      wait_cnt(3);
      rst_n = 1'b0;
      cyc();
      chk("rst_out", 32'(so_a), 0);
      rst_n = 1'b1;
      #1;
      check_all();
      run(30);

      // Out-of-range write on the 3-channel instance
      ch_en = 4'b0111;
      wr(3, 9);
      chk("b_upd_ign", 32'(up_b), 0);
      run(25);

      // Randomized traffic, including a full-range period
      for (int i = 0; i < 3000; i++) begin
         rst_n   = ($urandom_range(0, 199) != 0);
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_ch   = 2'($urandom_range(0, 3));
         wr_data = CW'($urandom_range(0, 30));
         if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0)
            period = ($urandom_range(0, 3) == 0) ? 8'd255 : CW'($urandom_range(0, 25));
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
